mem_wr_client: RTL and testbench

Initiator side of the `mem_intf_write` SW-write interface. Takes a burst command (start SRAM address, length) plus a word stream, buffers the words in a small FIFO, and presents them one beat at a time as `mem_req`/`mem_start_addr`/`mem_data`. Each beat completes on `mem_ack`. It sits between the software/host register block and the memory controller, driving the controller's SW-write request port.

---
 rtl/mem_wr_client_if.sv | 37 +++
 rtl/mem_wr_client.sv | 178 +++++++++++++++++
 tb/tb_mem_wr_client.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wr_client_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_wr_client_if : command, write-data and memory-beat signal bundle     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mem_wr_client_if #(
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [18:0]       cmd_addr;
  logic [4:0]        cmd_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              mem_req;
  logic [18:0]       mem_start_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_last;
  logic              mem_ack;
  logic              done;
  logic              err;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata, mem_ack,
    output cmd_ready, wdata_ready, mem_req, mem_start_addr, mem_data,
           mem_last, done, err, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata, mem_ack,
    input  cmd_ready, wdata_ready, mem_req, mem_start_addr, mem_data,
           mem_last, done, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_wr_client.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_wr_client : burst SW-write initiator, FIFO-buffered, one beat per ack|
// | Optional REQ timeout abort: MEM_WR_TIMEOUT_EN.  Rev 1.0                  |
// +--------------------------------------------------------------------------+
module mem_wr_client #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  mem_wr_client_if.master  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    REQ       = 2'd2,
    GAP       = 2'd3
  } state_t;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1))
  begin : g_param_check
    $error("mem_wr_client: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYC >= 1");
  end

  state_t            state_q;
  logic              cmd_ready_q, wdata_ready_q, mem_req_q, mem_last_q;
  logic              done_q, err_q, busy_q;
  logic [18:0]       addr_q, mem_addr_q;
  logic [4:0]        rem_q;
  logic [DATA_W-1:0] mem_data_q;

  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop, flush, fifo_empty;

  assign push       = bus.wdata_valid && wdata_ready_q;
  assign pop        = (state_q == REQ) && bus.mem_ack;
  assign fifo_empty = (count_q == '0);

`ifdef MEM_WR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  // Abort on the last un-acked REQ cycle so mem_req is high for exactly TIMEOUT_CYC cycles
  assign flush = (state_q == REQ) && !bus.mem_ack && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wdata_ready_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      wdata_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_last_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
`ifdef MEM_WR_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            addr_q <= bus.cmd_addr;
            rem_q  <= bus.cmd_len;
            if (bus.cmd_len == '0) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= WAIT_DATA;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
        end
        WAIT_DATA, GAP: begin
          if (!fifo_empty) begin
            state_q    <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= addr_q;
            mem_data_q <= fifo_q[rd_ptr_q];
            mem_last_q <= (rem_q == 5'd1);
`ifdef MEM_WR_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
          end else begin
            state_q <= WAIT_DATA;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            mem_req_q  <= 1'b0;
            mem_last_q <= 1'b0;
            addr_q     <= addr_q + 1'b1;
            rem_q      <= rem_q - 1'b1;
            if (rem_q == 5'd1) begin
              state_q     <= IDLE;
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q <= GAP;
            end
`ifdef MEM_WR_TIMEOUT_EN
          end else if (flush) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_last_q  <= 1'b0;
            err_q       <= 1'b1;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.wdata_ready    = wdata_ready_q;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_start_addr = mem_addr_q;
  assign bus.mem_data       = mem_data_q;
  assign bus.mem_last       = mem_last_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.busy           = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_wr_client.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_wr_client : directed self-checking bench for mem_wr_client        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_wr_client;
  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  mem_wr_client_if #(.DATA_W(32)) bus ();

  mem_wr_client #(.DATA_W(32), .FIFO_DEPTH(8), .TIMEOUT_CYC(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    bus.wdata_valid = 1'b1;
    bus.wdata       = d;
    tick();
    bus.wdata_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [18:0] a, input logic [4:0] l);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({bus.cmd_ready, bus.wdata_ready, bus.mem_req, bus.mem_last, bus.done, bus.err, bus.busy} !== 7'b0 ||
        bus.mem_start_addr !== 19'h0 || bus.mem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_values: flags=%b addr=%h data=%h, want all zero",
               {bus.cmd_ready, bus.wdata_ready, bus.mem_req, bus.mem_last, bus.done, bus.err, bus.busy},
               bus.mem_start_addr, bus.mem_data);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({bus.cmd_ready, bus.wdata_ready, bus.busy, bus.mem_req} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_release: rdy/wrdy/busy/req=%b want 1100",
               {bus.cmd_ready, bus.wdata_ready, bus.busy, bus.mem_req});
    end
  endtask

  task automatic test_single_beat();
    push_word(32'hA5A5_A5A5);
    send_cmd(19'h00010, 5'd1);
    vectors++;
    if ({bus.busy, bus.mem_req, bus.cmd_ready} !== 3'b100) begin
      miscompares++;
      $display("FAIL single_wait: busy/req/rdy=%b want 100", {bus.busy, bus.mem_req, bus.cmd_ready});
    end
    tick();
    vectors++;
    if ({bus.mem_req, bus.mem_last, bus.mem_start_addr, bus.mem_data} !== {1'b1, 1'b1, 19'h00010, 32'hA5A5_A5A5}) begin
      miscompares++;
      $display("FAIL single_req: req/last/addr/data=%b/%b/%h/%h want 1/1/00010/a5a5a5a5",
               bus.mem_req, bus.mem_last, bus.mem_start_addr, bus.mem_data);
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    vectors++;
    if ({bus.mem_req, bus.done, bus.busy, bus.cmd_ready} !== 4'b0101) begin
      miscompares++;
      $display("FAIL single_done: req/done/busy/rdy=%b want 0101", {bus.mem_req, bus.done, bus.busy, bus.cmd_ready});
    end
    tick();
    vectors++;
    if ({bus.mem_req, bus.done, bus.busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL single_after: req/done/busy=%b want 000", {bus.mem_req, bus.done, bus.busy});
    end
  endtask

  task automatic test_burst_wrap();
    logic [18:0] exp_addr [4];
    exp_addr = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
    for (int i = 1; i <= 4; i++) push_word(32'(i));
    send_cmd(19'h7FFFE, 5'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({bus.mem_req, bus.mem_last, bus.mem_start_addr, bus.mem_data} !== {1'b1, (i == 3), exp_addr[i], 32'(i + 1)}) begin
        miscompares++;
        $display("FAIL burst_beat%0d: req/last/addr/data=%b/%b/%h/%h want 1/%b/%h/%h",
                 i, bus.mem_req, bus.mem_last, bus.mem_start_addr, bus.mem_data, (i == 3), exp_addr[i], i + 1);
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      vectors++;
      if ({bus.mem_req, bus.done, bus.busy} !== ((i == 3) ? 3'b010 : 3'b001)) begin
        miscompares++;
        $display("FAIL burst_gap%0d: req/done/busy=%b want %b", i, {bus.mem_req, bus.done, bus.busy},
                 ((i == 3) ? 3'b010 : 3'b001));
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 3; i++) push_word(32'h1111_0000 + 32'(i));
    send_cmd(19'h00200, 5'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({bus.mem_req, bus.mem_last, bus.mem_start_addr, bus.mem_data} !==
          {1'b1, (i == 2), 19'h00200 + 19'(i), 32'h1111_0001 + 32'(i)}) begin
        miscompares++;
        $display("FAIL bp_beat%0d: req/last/addr/data=%b/%b/%h/%h", i, bus.mem_req, bus.mem_last,
                 bus.mem_start_addr, bus.mem_data);
      end
      if (i == 1) begin
        for (int k = 0; k < 10; k++) begin
          tick();
          vectors++;
          if ({bus.mem_req, bus.mem_start_addr, bus.mem_data} !== {1'b1, 19'h00201, 32'h1111_0002}) begin
            miscompares++;
            $display("FAIL bp_hold%0d: req/addr/data=%b/%h/%h want 1/00201/11110002", k,
                     bus.mem_req, bus.mem_start_addr, bus.mem_data);
          end
        end
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      vectors++;
      if ({bus.mem_req, bus.done} !== {1'b0, (i == 2)}) begin
        miscompares++;
        $display("FAIL bp_ack%0d: req/done=%b want 0%b", i, {bus.mem_req, bus.done}, (i == 2));
      end
    end
  endtask

  task automatic test_starvation();
    push_word(32'h0000_00D1);
    send_cmd(19'h00050, 5'd3);
    tick();
    vectors++;
    if ({bus.mem_req, bus.mem_data} !== {1'b1, 32'h0000_00D1}) begin
      miscompares++;
      $display("FAIL starve_beat0: req/data=%b/%h want 1/000000d1", bus.mem_req, bus.mem_data);
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if ({bus.mem_req, bus.busy} !== 2'b01) begin
        miscompares++;
        $display("FAIL starve_wait%0d: req/busy=%b want 01", k, {bus.mem_req, bus.busy});
      end
    end
    for (int i = 1; i < 3; i++) begin
      push_word(32'h0000_00D1 + 32'(i));
      vectors++;
      if (bus.mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL starve_push%0d: req=%b want 0", i, bus.mem_req);
      end
      tick();
      vectors++;
      if ({bus.mem_req, bus.mem_last, bus.mem_start_addr, bus.mem_data} !==
          {1'b1, (i == 2), 19'h00050 + 19'(i), 32'h0000_00D1 + 32'(i)}) begin
        miscompares++;
        $display("FAIL starve_beat%0d: req/last/addr/data=%b/%b/%h/%h", i, bus.mem_req, bus.mem_last,
                 bus.mem_start_addr, bus.mem_data);
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      if (i == 1) tick();
    end
    vectors++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL starve_done: done/busy=%b want 10", {bus.done, bus.busy});
    end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 9; i++) begin
      bus.wdata_valid = 1'b1;
      bus.wdata       = 32'hF000_0000 + 32'(i);
      tick();
      vectors++;
      if ({bus.wdata_ready, bus.mem_req} !== {(i < 7), 1'b0}) begin
        miscompares++;
        $display("FAIL full_push%0d: wrdy/req=%b want %b0", i, {bus.wdata_ready, bus.mem_req}, (i < 7));
      end
    end
    bus.wdata_valid = 1'b0;
  endtask

  task automatic test_illegal_len();
    send_cmd(19'h12345, 5'd0);
    vectors++;
    if ({bus.err, bus.mem_req, bus.busy, bus.cmd_ready, bus.wdata_ready} !== 5'b10010) begin
      miscompares++;
      $display("FAIL len0_err: err/req/busy/rdy/wrdy=%b want 10010",
               {bus.err, bus.mem_req, bus.busy, bus.cmd_ready, bus.wdata_ready});
    end
    tick();
    vectors++;
    if ({bus.err, bus.mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL len0_after: err/req=%b want 00", {bus.err, bus.mem_req});
    end
    // Draining shows the eight queued words survived and the ninth was refused
    send_cmd(19'h00400, 5'd8);
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if ({bus.mem_req, bus.mem_last, bus.mem_start_addr, bus.mem_data} !==
          {1'b1, (i == 7), 19'h00400 + 19'(i), 32'hF000_0000 + 32'(i)}) begin
        miscompares++;
        $display("FAIL drain_beat%0d: req/last/addr/data=%b/%b/%h/%h", i, bus.mem_req, bus.mem_last,
                 bus.mem_start_addr, bus.mem_data);
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      vectors++;
      if ({bus.mem_req, bus.done, bus.wdata_ready} !== {1'b0, (i == 7), 1'b1}) begin
        miscompares++;
        $display("FAIL drain_ack%0d: req/done/wrdy=%b want 0%b1", i, {bus.mem_req, bus.done, bus.wdata_ready}, (i == 7));
      end
    end
  endtask

`ifdef MEM_WR_TIMEOUT_EN
  task automatic test_timeout();
    push_word(32'h0000_0061);
    push_word(32'h0000_0062);
    send_cmd(19'h00300, 5'd2);
    for (int k = 0; k < 64; k++) begin
      tick();
      vectors++;
      if ({bus.mem_req, bus.err} !== 2'b10) begin
        miscompares++;
        $display("FAIL timeout_req%0d: req/err=%b want 10", k, {bus.mem_req, bus.err});
      end
    end
    tick();
    vectors++;
    if ({bus.mem_req, bus.err, bus.busy, bus.wdata_ready} !== 4'b0101) begin
      miscompares++;
      $display("FAIL timeout_abort: req/err/busy/wrdy=%b want 0101", {bus.mem_req, bus.err, bus.busy, bus.wdata_ready});
    end
    send_cmd(19'h00310, 5'd1);
    tick();
    vectors++;
    if ({bus.mem_req, bus.busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL timeout_flushed: req/busy=%b want 01", {bus.mem_req, bus.busy});
    end
    push_word(32'h0000_0077);
    tick();
    vectors++;
    if ({bus.mem_req, bus.mem_data} !== {1'b1, 32'h0000_0077}) begin
      miscompares++;
      $display("FAIL timeout_next: req/data=%b/%h want 1/00000077", bus.mem_req, bus.mem_data);
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
  endtask
`else
  task automatic test_timeout();
    push_word(32'h0000_005A);
    send_cmd(19'h00300, 5'd1);
    for (int k = 0; k < 100; k++) begin
      tick();
      vectors++;
      if ({bus.mem_req, bus.err, bus.mem_data} !== {1'b1, 1'b0, 32'h0000_005A}) begin
        miscompares++;
        $display("FAIL no_timeout%0d: req/err/data=%b/%b/%h want 1/0/0000005a", k, bus.mem_req, bus.err, bus.mem_data);
      end
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    vectors++;
    if ({bus.done, bus.err} !== 2'b10) begin
      miscompares++;
      $display("FAIL no_timeout_done: done/err=%b want 10", {bus.done, bus.err});
    end
  endtask
`endif

  task automatic test_reset_mid();
    push_word(32'h0000_00C1);
    push_word(32'h0000_00C2);
    send_cmd(19'h00700, 5'd2);
    tick();
    vectors++;
    if (bus.mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_req: req=%b want 1", bus.mem_req);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({bus.cmd_ready, bus.wdata_ready, bus.mem_req, bus.mem_last, bus.done, bus.err, bus.busy} !== 7'b0 ||
        bus.mem_start_addr !== 19'h0 || bus.mem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_values: flags=%b addr=%h data=%h, want all zero",
               {bus.cmd_ready, bus.wdata_ready, bus.mem_req, bus.mem_last, bus.done, bus.err, bus.busy},
               bus.mem_start_addr, bus.mem_data);
    end
    rst = 1'b0;
    tick();
    send_cmd(19'h00800, 5'd1);
    tick();
    vectors++;
    if ({bus.mem_req, bus.busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL rstmid_flushed: req/busy=%b want 01", {bus.mem_req, bus.busy});
    end
    push_word(32'h0000_00EE);
    tick();
    vectors++;
    if ({bus.mem_req, bus.mem_last, bus.mem_start_addr, bus.mem_data} !== {1'b1, 1'b1, 19'h00800, 32'h0000_00EE}) begin
      miscompares++;
      $display("FAIL rstmid_next: req/last/addr/data=%b/%b/%h/%h want 1/1/00800/000000ee",
               bus.mem_req, bus.mem_last, bus.mem_start_addr, bus.mem_data);
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    vectors++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL rstmid_done: done/busy=%b want 10", {bus.done, bus.busy});
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.mem_ack     = 1'b0;
    test_reset();
    test_single_beat();
    test_burst_wrap();
    test_backpressure();
    test_starvation();
    test_fifo_full();
    test_illegal_len();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
